// File: rtl/bsg_axil_fifo_pkg.sv
// Shared types and AXI response codes for the AXI-Lite to host FIFO bridge.
`ifndef BSG_AXIL_FIFO_PKG_SV
`define BSG_AXIL_FIFO_PKG_SV

`define BSG_AXIL_FIFO_DECLARE_STRUCTS(addr_w, data_w) \
  typedef struct packed { \
    logic [addr_w-1:0]     addr; \
    logic [data_w-1:0]     data; \
    logic [(data_w/8)-1:0] strb; \
  } axil_wr_req_s; \
  typedef struct packed { \
    logic [1:0]        resp; \
    logic [data_w-1:0] data; \
  } axil_rd_rsp_s;

package bsg_axil_fifo_pkg;
  localparam logic [1:0] axi_resp_okay_gp   = 2'b00;
  localparam logic [1:0] axi_resp_slverr_gp = 2'b10;

  function automatic int pending_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

`endif

// File: rtl/bsg_axil_aw_w_join.sv
// Pairs AW and W beats arriving in either order and tracks writes counted against
// the outstanding limit (wr_total) and writes still awaiting a host response (wr_host).
module bsg_axil_aw_w_join
  import bsg_axil_fifo_pkg::*;
  #(parameter int addr_width_p  = 32
  , parameter int data_width_p  = 32
  , parameter int outstanding_p = 4
  , localparam int pend_w_lp = pending_width(outstanding_p)
  , localparam int strb_w_lp = data_width_p / 8)
  (input  logic                    clk_i
  , input  logic                    reset_i
  , input  logic [addr_width_p-1:0] awaddr_i
  , input  logic [2:0]              awprot_i
  , input  logic                    awvalid_i
  , output logic                    awready_o
  , input  logic [data_width_p-1:0] wdata_i
  , input  logic [strb_w_lp-1:0]    wstrb_i
  , input  logic                    wvalid_i
  , output logic                    wready_o
  , input  logic                    req_ready_i
  , output logic                    join_o
  , output logic [addr_width_p-1:0] addr_o
  , output logic [data_width_p-1:0] data_o
  , output logic [strb_w_lp-1:0]    strb_o
  , input  logic                    rsp_push_i
  , input  logic                    b_fire_i
  , output logic [pend_w_lp-1:0]    wr_total_o
  , output logic                    host_pending_o
  );

  logic                 aw_v_r, w_v_r;
  logic                 aw_fire, w_fire;
  logic [pend_w_lp-1:0] wr_total_r, wr_host_r;
  logic [2:0]           awprot_unused_r;

  // A hold register frees up in the same cycle it joins, so back-to-back writes stream.
  assign join_o    = aw_v_r & w_v_r & req_ready_i & (wr_total_r < pend_w_lp'(outstanding_p));
  assign awready_o = ~aw_v_r | join_o;
  assign wready_o  = ~w_v_r | join_o;
  assign aw_fire   = awvalid_i & awready_o;
  assign w_fire    = wvalid_i & wready_o;

  assign wr_total_o     = wr_total_r;
  assign host_pending_o = (wr_host_r != '0);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      aw_v_r     <= 1'b0;
      w_v_r      <= 1'b0;
      wr_total_r <= '0;
      wr_host_r  <= '0;
    end else begin
      if (aw_fire)     aw_v_r <= 1'b1;
      else if (join_o) aw_v_r <= 1'b0;
      if (w_fire)      w_v_r  <= 1'b1;
      else if (join_o) w_v_r  <= 1'b0;
      case ({join_o, b_fire_i})
        2'b10:   wr_total_r <= wr_total_r + pend_w_lp'(1);
        2'b01:   wr_total_r <= wr_total_r - pend_w_lp'(1);
        default: ;
      endcase
      case ({join_o, rsp_push_i})
        2'b10:   wr_host_r <= wr_host_r + pend_w_lp'(1);
        2'b01:   wr_host_r <= wr_host_r - pend_w_lp'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (aw_fire) begin
      addr_o          <= awaddr_i;
      awprot_unused_r <= awprot_i;
    end
    if (w_fire) begin
      data_o <= wdata_i;
      strb_o <= wstrb_i;
    end
  end

endmodule

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular-buffer FIFO: ready_o is simply "not full", v_o is "not empty".
module bsg_fifo_1r1w_small
  #(parameter int width_p = 8
  , parameter int els_p   = 4
  , localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1
  , localparam int cnt_w_lp = $clog2(els_p + 1))
  (input  logic               clk_i
  , input  logic               reset_i
  , input  logic               v_i
  , output logic               ready_o
  , input  logic [width_p-1:0] data_i
  , output logic               v_o
  , output logic [width_p-1:0] data_o
  , input  logic               yumi_i
  );

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] rptr_r, wptr_r;
  logic [cnt_w_lp-1:0] count_r;
  logic                enq, deq;

  function automatic logic [ptr_w_lp-1:0] bump(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  assign ready_o = (count_r != cnt_w_lp'(els_p));
  assign v_o     = (count_r != '0);
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;
  assign data_o  = mem_r[rptr_r];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rptr_r  <= '0;
      wptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (enq) wptr_r <= bump(wptr_r);
      if (deq) rptr_r <= bump(rptr_r);
      case ({enq, deq})
        2'b10:   count_r <= count_r + cnt_w_lp'(1);
        2'b01:   count_r <= count_r - cnt_w_lp'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r] <= data_i;
  end

  a_yumi_valid: assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o))
    else $error("fifo yumi_i asserted while empty");

endmodule

// File: rtl/bsg_axil_to_fifo_bridge.sv
// AXI4-Lite subordinate that queues write/read requests toward a host and returns
// host-supplied responses in order, with separate outstanding limits per direction.
module bsg_axil_to_fifo_bridge
  import bsg_axil_fifo_pkg::*;
  #(parameter int addr_width_p  = 32
  , parameter int data_width_p  = 32
  , parameter int req_els_p     = 4
  , parameter int outstanding_p = 4
  , localparam int pend_w_lp   = pending_width(outstanding_p)
  , localparam int strb_w_lp   = data_width_p / 8
  , localparam int wr_req_w_lp = addr_width_p + data_width_p + strb_w_lp)
  (input  logic                    clk_i
  , input  logic                    async_reset_i
  , input  logic [addr_width_p-1:0] awaddr_i
  , input  logic [2:0]              awprot_i
  , input  logic                    awvalid_i
  , output logic                    awready_o
  , input  logic [data_width_p-1:0] wdata_i
  , input  logic [strb_w_lp-1:0]    wstrb_i
  , input  logic                    wvalid_i
  , output logic                    wready_o
  , output logic [1:0]              bresp_o
  , output logic                    bvalid_o
  , input  logic                    bready_i
  , input  logic [addr_width_p-1:0] araddr_i
  , input  logic [2:0]              arprot_i
  , input  logic                    arvalid_i
  , output logic                    arready_o
  , output logic [data_width_p-1:0] rdata_o
  , output logic [1:0]              rresp_o
  , output logic                    rvalid_o
  , input  logic                    rready_i
  , output logic [wr_req_w_lp-1:0]  wr_req_o
  , output logic                    wr_req_v_o
  , input  logic                    wr_req_yumi_i
  , input  logic [1:0]              wr_rsp_i
  , input  logic                    wr_rsp_v_i
  , output logic                    wr_rsp_ready_o
  , output logic [addr_width_p-1:0] rd_req_o
  , output logic                    rd_req_v_o
  , input  logic                    rd_req_yumi_i
  , input  logic [data_width_p+1:0] rd_rsp_i
  , input  logic                    rd_rsp_v_i
  , output logic                    rd_rsp_ready_o
  , output logic [pend_w_lp-1:0]    wr_pending_o
  , output logic [pend_w_lp-1:0]    rd_pending_o
  );

  `BSG_AXIL_FIFO_DECLARE_STRUCTS(addr_width_p, data_width_p)

  // Handshakes: a transfer happens on a clock edge where valid & ready (AXI side)
  // or v & yumi/ready (host side); ready never depends combinationally on valid.
  axil_wr_req_s              wr_req_in;
  axil_rd_rsp_s              r_head;
  logic                      wr_join, wr_req_ready, b_ready, host_wr_pending;
  logic                      wr_rsp_push, b_fire;
  logic [addr_width_p-1:0]   join_addr;
  logic [data_width_p-1:0]   join_data;
  logic [strb_w_lp-1:0]      join_strb;

  bsg_axil_aw_w_join #(
    .addr_width_p (addr_width_p)
  , .data_width_p (data_width_p)
  , .outstanding_p(outstanding_p)
  ) aw_w_join (
    .clk_i         (clk_i)
  , .reset_i       (async_reset_i)
  , .awaddr_i      (awaddr_i)
  , .awprot_i      (awprot_i)
  , .awvalid_i     (awvalid_i)
  , .awready_o     (awready_o)
  , .wdata_i       (wdata_i)
  , .wstrb_i       (wstrb_i)
  , .wvalid_i      (wvalid_i)
  , .wready_o      (wready_o)
  , .req_ready_i   (wr_req_ready)
  , .join_o        (wr_join)
  , .addr_o        (join_addr)
  , .data_o        (join_data)
  , .strb_o        (join_strb)
  , .rsp_push_i    (wr_rsp_push)
  , .b_fire_i      (b_fire)
  , .wr_total_o    (wr_pending_o)
  , .host_pending_o(host_wr_pending)
  );

  assign wr_req_in = '{addr: join_addr, data: join_data, strb: join_strb};

  bsg_fifo_1r1w_small #(.width_p(wr_req_w_lp), .els_p(req_els_p)) wr_req_fifo (
    .clk_i(clk_i), .reset_i(async_reset_i)
  , .v_i(wr_join), .ready_o(wr_req_ready), .data_i(wr_req_in)
  , .v_o(wr_req_v_o), .data_o(wr_req_o), .yumi_i(wr_req_yumi_i)
  );

  // B FIFO holds at most wr_total entries, so it cannot overflow at depth outstanding_p.
  assign wr_rsp_ready_o = host_wr_pending & b_ready;
  assign wr_rsp_push    = wr_rsp_v_i & wr_rsp_ready_o;
  assign b_fire         = bvalid_o & bready_i;

  bsg_fifo_1r1w_small #(.width_p(2), .els_p(outstanding_p)) b_fifo (
    .clk_i(clk_i), .reset_i(async_reset_i)
  , .v_i(wr_rsp_push), .ready_o(b_ready), .data_i(wr_rsp_i)
  , .v_o(bvalid_o), .data_o(bresp_o), .yumi_i(b_fire)
  );

  logic [pend_w_lp-1:0] rd_total_r, rd_host_r;
  logic                 rd_req_ready, r_ready, ar_fire, rd_rsp_push, r_fire;
  logic [2:0]           arprot_unused_r;

  assign arready_o      = rd_req_ready & (rd_total_r < pend_w_lp'(outstanding_p));
  assign ar_fire        = arvalid_i & arready_o;
  assign rd_rsp_ready_o = (rd_host_r != '0) & r_ready;
  assign rd_rsp_push    = rd_rsp_v_i & rd_rsp_ready_o;
  assign r_fire         = rvalid_o & rready_i;
  assign rd_pending_o   = rd_total_r;

  always_ff @(posedge clk_i or posedge async_reset_i) begin
    if (async_reset_i) begin
      rd_total_r      <= '0;
      rd_host_r       <= '0;
      arprot_unused_r <= '0;
    end else begin
      if (ar_fire) arprot_unused_r <= arprot_i;
      case ({ar_fire, r_fire})
        2'b10:   rd_total_r <= rd_total_r + pend_w_lp'(1);
        2'b01:   rd_total_r <= rd_total_r - pend_w_lp'(1);
        default: ;
      endcase
      case ({ar_fire, rd_rsp_push})
        2'b10:   rd_host_r <= rd_host_r + pend_w_lp'(1);
        2'b01:   rd_host_r <= rd_host_r - pend_w_lp'(1);
        default: ;
      endcase
    end
  end

  bsg_fifo_1r1w_small #(.width_p(addr_width_p), .els_p(req_els_p)) rd_req_fifo (
    .clk_i(clk_i), .reset_i(async_reset_i)
  , .v_i(ar_fire), .ready_o(rd_req_ready), .data_i(araddr_i)
  , .v_o(rd_req_v_o), .data_o(rd_req_o), .yumi_i(rd_req_yumi_i)
  );

  bsg_fifo_1r1w_small #(.width_p(data_width_p + 2), .els_p(outstanding_p)) r_fifo (
    .clk_i(clk_i), .reset_i(async_reset_i)
  , .v_i(rd_rsp_push), .ready_o(r_ready), .data_i(rd_rsp_i)
  , .v_o(rvalid_o), .data_o(r_head), .yumi_i(r_fire)
  );

  assign rresp_o = r_head.resp;
  assign rdata_o = r_head.data;

  a_wr_rsp_ready: assert property (@(posedge clk_i) disable iff (async_reset_i)
    !(wr_rsp_v_i && !wr_rsp_ready_o)) else $error("wr_rsp push while not ready");
  a_rd_rsp_ready: assert property (@(posedge clk_i) disable iff (async_reset_i)
    !(rd_rsp_v_i && !rd_rsp_ready_o)) else $error("rd_rsp push while not ready");

endmodule

// File: tb/tb_bsg_axil_to_fifo_bridge.sv
// Directed bench for bsg_axil_to_fifo_bridge: table-driven write/read vectors plus
// hand sequences for the outstanding limit and mid-operation reset.
module tb_bsg_axil_to_fifo_bridge;
  import bsg_axil_fifo_pkg::*;

  localparam int aw_p  = 32;
  localparam int dw_p  = 32;
  localparam int sw_p  = 4;
  localparam int pw_p  = 3;
  localparam int req_w = aw_p + dw_p + sw_p;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic async_reset_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic [aw_p-1:0]   awaddr_i, araddr_i;
  logic [2:0]        awprot_i, arprot_i;
  logic              awvalid_i, awready_o, wvalid_i, wready_o;
  logic [dw_p-1:0]   wdata_i, rdata_o;
  logic [sw_p-1:0]   wstrb_i;
  logic [1:0]        bresp_o, rresp_o, wr_rsp_i;
  logic              bvalid_o, bready_i, arvalid_i, arready_o, rvalid_o, rready_i;
  logic [req_w-1:0]  wr_req_o;
  logic              wr_req_v_o, wr_req_yumi_i, wr_rsp_v_i, wr_rsp_ready_o;
  logic [aw_p-1:0]   rd_req_o;
  logic              rd_req_v_o, rd_req_yumi_i, rd_rsp_v_i, rd_rsp_ready_o;
  logic [dw_p+1:0]   rd_rsp_i;
  logic [pw_p-1:0]   wr_pending_o, rd_pending_o;

  bsg_axil_to_fifo_bridge #(
    .addr_width_p(aw_p), .data_width_p(dw_p), .req_els_p(4), .outstanding_p(4)
  ) dut (
    .clk_i(clk_i), .async_reset_i(async_reset_i)
  , .awaddr_i(awaddr_i), .awprot_i(awprot_i), .awvalid_i(awvalid_i), .awready_o(awready_o)
  , .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wvalid_i(wvalid_i), .wready_o(wready_o)
  , .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i)
  , .araddr_i(araddr_i), .arprot_i(arprot_i), .arvalid_i(arvalid_i), .arready_o(arready_o)
  , .rdata_o(rdata_o), .rresp_o(rresp_o), .rvalid_o(rvalid_o), .rready_i(rready_i)
  , .wr_req_o(wr_req_o), .wr_req_v_o(wr_req_v_o), .wr_req_yumi_i(wr_req_yumi_i)
  , .wr_rsp_i(wr_rsp_i), .wr_rsp_v_i(wr_rsp_v_i), .wr_rsp_ready_o(wr_rsp_ready_o)
  , .rd_req_o(rd_req_o), .rd_req_v_o(rd_req_v_o), .rd_req_yumi_i(rd_req_yumi_i)
  , .rd_rsp_i(rd_rsp_i), .rd_rsp_v_i(rd_rsp_v_i), .rd_rsp_ready_o(rd_rsp_ready_o)
  , .wr_pending_o(wr_pending_o), .rd_pending_o(rd_pending_o)
  );

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;
  logic [req_w-1:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    awaddr_i = '0; awprot_i = '0; awvalid_i = 1'b0;
    wdata_i = '0; wstrb_i = '0; wvalid_i = 1'b0; bready_i = 1'b0;
    araddr_i = '0; arprot_i = '0; arvalid_i = 1'b0; rready_i = 1'b0;
    wr_req_yumi_i = 1'b0; wr_rsp_i = '0; wr_rsp_v_i = 1'b0;
    rd_req_yumi_i = 1'b0; rd_rsp_i = '0; rd_rsp_v_i = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    logic [1:0]  resp;
    logic [67:0] exp_req;
    logic [1:0]  exp_bresp;
  } wr_vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
    int          stall;
    logic [31:0] exp_rd_req;
    logic [1:0]  exp_rresp;
    logic [31:0] exp_rdata;
  } rd_vec_t;

  wr_vec_t wr_tab[4];
  rd_vec_t rd_tab[3];

  task automatic run_write(input wr_vec_t v);
    int last;
    last = (v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly;
    awaddr_i = v.addr; awprot_i = 3'd2; wdata_i = v.data; wstrb_i = v.strb;
    for (int c = 0; c <= last; c++) begin
      awvalid_i = (c == v.aw_dly);
      wvalid_i  = (c == v.w_dly);
      if (c > v.w_dly)  check("wready_held", wready_o, 1'b0);
      if (c > v.aw_dly) check("awready_held", awready_o, 1'b0);
      step();
    end
    awvalid_i = 1'b0; wvalid_i = 1'b0;
    check("wr_req_v_early", wr_req_v_o, 1'b0);
    step();
    check("wr_req_v", wr_req_v_o, 1'b1);
    check("wr_req", wr_req_o, v.exp_req);
    check("wr_pending_1", wr_pending_o, 3'd1);
    wr_req_yumi_i = 1'b1; step(); wr_req_yumi_i = 1'b0;
    check("wr_req_v_drained", wr_req_v_o, 1'b0);
    check("wr_rsp_ready", wr_rsp_ready_o, 1'b1);
    wr_rsp_i = v.resp; wr_rsp_v_i = 1'b1; step(); wr_rsp_v_i = 1'b0;
    check("bvalid", bvalid_o, 1'b1);
    check("bresp", bresp_o, v.exp_bresp);
    check("wr_rsp_ready_after", wr_rsp_ready_o, 1'b0);
    bready_i = 1'b1; step(); bready_i = 1'b0;
    check("bvalid_done", bvalid_o, 1'b0);
    check("wr_pending_0", wr_pending_o, 3'd0);
  endtask

  task automatic run_read(input rd_vec_t v);
    check("arready", arready_o, 1'b1);
    araddr_i = v.addr; arprot_i = 3'd1; arvalid_i = 1'b1; step(); arvalid_i = 1'b0;
    check("rd_req_v", rd_req_v_o, 1'b1);
    check("rd_req", rd_req_o, v.exp_rd_req);
    check("rd_pending_1", rd_pending_o, 3'd1);
    rd_req_yumi_i = 1'b1; step(); rd_req_yumi_i = 1'b0;
    check("rd_rsp_ready", rd_rsp_ready_o, 1'b1);
    rd_rsp_i = {v.resp, v.data}; rd_rsp_v_i = 1'b1; step(); rd_rsp_v_i = 1'b0; rd_rsp_i = '0;
    for (int s = 0; s < v.stall; s++) begin
      check("rvalid_hold", rvalid_o, 1'b1);
      check("rresp_hold", rresp_o, v.exp_rresp);
      check("rdata_hold", rdata_o, v.exp_rdata);
      step();
    end
    check("rvalid", rvalid_o, 1'b1);
    check("rresp", rresp_o, v.exp_rresp);
    check("rdata", rdata_o, v.exp_rdata);
    rready_i = 1'b1; step(); rready_i = 1'b0;
    check("rvalid_done", rvalid_o, 1'b0);
    check("rd_pending_0", rd_pending_o, 3'd0);
  endtask

  // ---------------- test ----------------
  int   sent;
  logic fire;

  initial begin
    wr_tab[0] = '{32'h10, 32'hDEADBEEF, 4'hF, 0, 0, axi_resp_okay_gp,
                  68'h00000010DEADBEEFF, 2'd0};
    wr_tab[1] = '{32'h14, 32'h0BADF00D, 4'h3, 5, 0, axi_resp_slverr_gp,
                  68'h000000140BADF00D3, 2'd2};
    wr_tab[2] = '{32'h18, 32'hCAFEF00D, 4'hC, 0, 5, axi_resp_okay_gp,
                  68'h00000018CAFEF00DC, 2'd0};
    wr_tab[3] = '{32'hFFFFFFFC, 32'hFFFFFFFF, 4'h1, 2, 1, axi_resp_slverr_gp,
                  68'hFFFFFFFCFFFFFFFF1, 2'd2};
    rd_tab[0] = '{32'h20, 32'h12345678, axi_resp_slverr_gp, 3, 32'h20, 2'd2, 32'h12345678};
    rd_tab[1] = '{32'h24, 32'hA5A5A5A5, axi_resp_okay_gp, 0, 32'h24, 2'd0, 32'hA5A5A5A5};
    rd_tab[2] = '{32'hFFFFFFF0, 32'h0, axi_resp_okay_gp, 1, 32'hFFFFFFF0, 2'd0, 32'h0};

    idle_inputs();
    async_reset_i = 1'b1;
    step(); step(); step();
    async_reset_i = 1'b0;
    step();
    check("rst_awready", awready_o, 1'b1);
    check("rst_wready", wready_o, 1'b1);
    check("rst_arready", arready_o, 1'b1);
    check("rst_bvalid", bvalid_o, 1'b0);
    check("rst_rvalid", rvalid_o, 1'b0);
    check("rst_wr_req_v", wr_req_v_o, 1'b0);
    check("rst_rd_req_v", rd_req_v_o, 1'b0);
    check("rst_wr_rsp_ready", wr_rsp_ready_o, 1'b0);
    check("rst_rd_rsp_ready", rd_rsp_ready_o, 1'b0);
    check("rst_wr_pending", wr_pending_o, 3'd0);
    check("rst_rd_pending", rd_pending_o, 3'd0);

    for (int i = 0; i < 4; i++) run_write(wr_tab[i]);
    for (int i = 0; i < 3; i++) run_read(rd_tab[i]);

    // Outstanding limit: five back-to-back writes, host silent, B always ready.
    exp_q.delete();
    sent = 0;
    bready_i = 1'b1;
    for (int c = 0; c < 20 && sent < 5; c++) begin
      awaddr_i = 32'h100 + 32'(4 * sent);
      wdata_i  = 32'hA0000000 + 32'(sent);
      wstrb_i  = 4'hF;
      awvalid_i = 1'b1; wvalid_i = 1'b1;
      fire = awready_o & wready_o;
      step();
      if (fire) begin
        exp_q.push_back({awaddr_i, wdata_i, wstrb_i});
        sent++;
      end
    end
    awvalid_i = 1'b0; wvalid_i = 1'b0;
    check("ow_sent", 128'(sent), 128'd5);
    step(); step();
    check("ow_pending", wr_pending_o, 3'd4);
    check("ow_awready", awready_o, 1'b0);
    check("ow_wready", wready_o, 1'b0);
    check("ow_wr_req_v", wr_req_v_o, 1'b1);
    check("ow_head", wr_req_o, exp_q.pop_front());
    wr_req_yumi_i = 1'b1; step(); wr_req_yumi_i = 1'b0;
    check("ow_pending_after_pop", wr_pending_o, 3'd4);
    wr_rsp_i = axi_resp_okay_gp; wr_rsp_v_i = 1'b1; step(); wr_rsp_v_i = 1'b0;
    check("ow_bvalid", bvalid_o, 1'b1);
    step();
    check("ow_pending_3", wr_pending_o, 3'd3);
    check("ow_awready_join", awready_o, 1'b1);
    step();
    check("ow_pending_refill", wr_pending_o, 3'd4);
    check("ow_bvalid_gone", bvalid_o, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check("ow_drain_v", wr_req_v_o, 1'b1);
      check("ow_drain", wr_req_o, exp_q.pop_front());
      wr_req_yumi_i = 1'b1; step(); wr_req_yumi_i = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      wr_rsp_v_i = 1'b1;
      step();
    end
    wr_rsp_v_i = 1'b0;
    for (int c = 0; c < 10 && wr_pending_o != '0; c++) step();
    check("ow_drained", wr_pending_o, 3'd0);
    check("ow_queue_empty", 128'(exp_q.size()), 128'd0);
    bready_i = 1'b0;

    // Mid-operation reset with two writes and one read in flight.
    awaddr_i = 32'h200; wdata_i = 32'h11111111; wstrb_i = 4'hF;
    awvalid_i = 1'b1; wvalid_i = 1'b1; step();
    awaddr_i = 32'h204; wdata_i = 32'h22222222; step();
    awvalid_i = 1'b0; wvalid_i = 1'b0;
    araddr_i = 32'h300; arvalid_i = 1'b1; step(); arvalid_i = 1'b0;
    step();
    wr_req_yumi_i = 1'b1; step(); wr_req_yumi_i = 1'b0;
    wr_rsp_i = axi_resp_okay_gp; wr_rsp_v_i = 1'b1; step(); wr_rsp_v_i = 1'b0;
    check("pre_rst_wr_req_v", wr_req_v_o, 1'b1);
    check("pre_rst_rd_req_v", rd_req_v_o, 1'b1);
    check("pre_rst_bvalid", bvalid_o, 1'b1);
    check("pre_rst_wr_pending", wr_pending_o, 3'd2);
    check("pre_rst_rd_pending", rd_pending_o, 3'd1);
    #2;
    async_reset_i = 1'b1;
    #1;
    check("mid_rst_wr_req_v", wr_req_v_o, 1'b0);
    check("mid_rst_rd_req_v", rd_req_v_o, 1'b0);
    check("mid_rst_bvalid", bvalid_o, 1'b0);
    check("mid_rst_rvalid", rvalid_o, 1'b0);
    check("mid_rst_wr_pending", wr_pending_o, 3'd0);
    check("mid_rst_rd_pending", rd_pending_o, 3'd0);
    check("mid_rst_wr_rsp_ready", wr_rsp_ready_o, 1'b0);
    step(); step();
    async_reset_i = 1'b0;
    step();
    check("post_rst_awready", awready_o, 1'b1);
    check("post_rst_wready", wready_o, 1'b1);
    check("post_rst_arready", arready_o, 1'b1);

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
